// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS register addressing constants and types
package mips_pkg;
   localparam int REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
   localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd29;
   localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [31:0]           word_t;
endpackage

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - one combinational register file read port
module rf_read_port
   import mips_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32,
   parameter bit BYPASS   = 1'b0,
   parameter int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] regs [NUM_REGS],
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] data
);
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NUM_REGS);

   logic in_range;
   logic is_zero;

   assign in_range = {1'b0, addr} < LIMIT;
   assign is_zero  = (addr == ADDR_W'(REG_ZERO));

   // Bypass is gated by rst_n so a write presented during reset never leaks out.
   always_comb begin
      data = '0;
      if (rst_n && in_range && !is_zero) begin
         if (BYPASS && wr_en && (wr_addr == addr))
            data = wr_data;
         else
            data = regs[addr];
      end
   end
endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - MIPS 32x32 GPR file, two read ports, one write port
module reg_file
   import mips_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32,
   parameter bit BYPASS   = 1'b0,
   parameter int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [15:0]       wr_count
);
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NUM_REGS);

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic              wr_ok;

   assign wr_ok = wr_en && (wr_addr != ADDR_W'(REG_ZERO)) && ({1'b0, wr_addr} < LIMIT);

   // Flops rather than RAM: every entry must clear asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= '0;
         wr_count <= '0;
      end else if (wr_ok) begin
         regs[wr_addr] <= wr_data;
         if (wr_count != 16'hFFFF)
            wr_count <= wr_count + 16'd1;
      end
   end

   rf_read_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .BYPASS(BYPASS), .ADDR_W(ADDR_W)) u_port1 (
      .rst_n   (rst_n),
      .addr    (rd_addr1),
      .regs    (regs),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .data    (rd_data1)
   );

   rf_read_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .BYPASS(BYPASS), .ADDR_W(ADDR_W)) u_port2 (
      .rst_n   (rst_n),
      .addr    (rd_addr2),
      .regs    (regs),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .data    (rd_data2)
   );
endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed self-checking bench for reg_file, BYPASS=0 and BYPASS=1
module tb_reg_file;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   reg_addr_t   rd_addr1, rd_addr2, wr_addr;
   logic        wr_en;
   word_t       wr_data;
   word_t       a_rd1, a_rd2, b_rd1, b_rd2;
   logic [15:0] a_cnt, b_cnt;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   reg_file #(.DATA_W(32), .NUM_REGS(32), .BYPASS(1'b0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(a_rd1), .rd_data2(a_rd2), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_count(a_cnt)
   );

   reg_file #(.DATA_W(32), .NUM_REGS(32), .BYPASS(1'b1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(b_rd1), .rd_data2(b_rd2), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_count(b_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Write presented at a negedge, committed at the next posedge, inputs released afterwards.
   task automatic do_write(input reg_addr_t a, input word_t d);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rd_addr1 = '0; rd_addr2 = '0;
      repeat (2) @(negedge clk);
      check("reset_cnt0", {16'h0, a_cnt}, 32'h0);
      check("reset_cnt1", {16'h0, b_cnt}, 32'h0);
      rd_addr1 = 5'd5; #1;
      check("reset_rd", a_rd1, 32'h0);
      rst_n = 1'b1;

      // basic write then read
      do_write(5'd5, 32'hDEADBEEF);
      rd_addr1 = 5'd5; #1;
      check("wr_r5_dut0", a_rd1, 32'hDEADBEEF);
      check("wr_r5_dut1", b_rd1, 32'hDEADBEEF);
      check("wr_cnt_1", {16'h0, a_cnt}, 32'd1);

      // writes to $zero are silent, including through bypass
      @(negedge clk);
      wr_en = 1'b1; wr_addr = REG_ZERO; wr_data = 32'hFFFFFFFF;
      rd_addr1 = REG_ZERO; rd_addr2 = REG_ZERO; #1;
      check("zero_byp1", b_rd1, 32'h0);
      check("zero_byp2", b_rd2, 32'h0);
      @(negedge clk);
      wr_en = 1'b0; #1;
      check("zero_rd1", a_rd1, 32'h0);
      check("zero_rd2", a_rd2, 32'h0);
      check("zero_cnt", {16'h0, a_cnt}, 32'd1);
      check("zero_cnt1", {16'h0, b_cnt}, 32'd1);

      // same-cycle read of write address
      do_write(5'd7, 32'h11);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h22; rd_addr1 = 5'd7; rd_addr2 = 5'd5; #1;
      check("nobyp_old", a_rd1, 32'h11);
      check("byp_new", b_rd1, 32'h22);
      check("byp_other_port", b_rd2, 32'hDEADBEEF);
      @(negedge clk);
      wr_en = 1'b0; #1;
      check("nobyp_next", a_rd1, 32'h22);
      check("cnt_3", {16'h0, a_cnt}, 32'd3);

      // dual port
      do_write(REG_RA, 32'h0040_0010);
      do_write(5'd3, 32'h0000_0333);
      do_write(5'd4, 32'h0000_0444);
      rd_addr1 = REG_RA; rd_addr2 = REG_RA; #1;
      check("dual_same1", a_rd1, 32'h0040_0010);
      check("dual_same2", a_rd2, 32'h0040_0010);
      rd_addr1 = 5'd3; rd_addr2 = 5'd4; #1;
      check("dual_p1", a_rd1, 32'h0000_0333);
      check("dual_p2", a_rd2, 32'h0000_0444);
      check("dual_p1_b", b_rd1, 32'h0000_0333);
      check("dual_p2_b", b_rd2, 32'h0000_0444);
      check("cnt_6", {16'h0, b_cnt}, 32'd6);

      // asynchronous reset mid-cycle, with a write presented during reset
      @(negedge clk);
      #2 rst_n = 1'b0;
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hABCD_0000; #1;
      check("arst_cnt0", {16'h0, a_cnt}, 32'h0);
      check("arst_cnt1", {16'h0, b_cnt}, 32'h0);
      for (int i = 0; i < 32; i++) begin
         rd_addr1 = 5'(i); rd_addr2 = 5'(31 - i); #1;
         check($sformatf("arst_a%0d", i), a_rd1 | a_rd2, 32'h0);
         check($sformatf("arst_b%0d", i), b_rd1 | b_rd2, 32'h0);
      end
      @(negedge clk);
      wr_en = 1'b0; rd_addr1 = 5'd3; #1;
      check("arst_wr_drop", a_rd1, 32'h0);
      rst_n = 1'b1;

      // counter saturation
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 5'd1;
      for (int i = 0; i < 65535; i++) begin
         wr_data = 32'(i);
         @(negedge clk);
      end
      check("sat_ffff", {16'h0, a_cnt}, 32'h0000_FFFF);
      wr_data = 32'h0001_0000;
      @(negedge clk);
      wr_en = 1'b0; rd_addr1 = 5'd1; #1;
      check("sat_hold", {16'h0, a_cnt}, 32'h0000_FFFF);
      check("sat_hold_b", {16'h0, b_cnt}, 32'h0000_FFFF);
      check("sat_r1", a_rd1, 32'h0001_0000);
      rst_n = 1'b0; #1;
      check("sat_rst", {16'h0, a_cnt}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
